// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampled rx line to a valid/ack byte register with frame-error and overrun flags.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd/even) and the rx_parity_err pulse.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,parameter int PARITY_ODD = 0
`endif
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 baud_tick,
   input  logic                 rx,
   input  logic                 rx_ack,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_frame_err,
   output logic                 rx_overrun,
   output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
  ,output logic                 rx_parity_err
`endif
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] TMAX  = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TMID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TONE  = TW'(1);
   localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

   state_t                 state_q;
   logic [1:0]             sync_q;
   logic [TW-1:0]          tcnt_q;
   logic [BW-1:0]          bcnt_q;
   logic [DATA_BITS-1:0]   shift_q;
   logic [DATA_BITS-1:0]   data_q;
   logic                   valid_q;
   logic                   ferr_q;
   logic                   ovr_q;
   logic                   busy_q;
   logic                   rx_s;
   logic                   frame_ok;
`ifdef UART_RX_PARITY_EN
   localparam logic PAR_ODD = PARITY_ODD[0];
   logic                   par_bad_q;
   logic                   perr_q;
   assign rx_parity_err = perr_q;
`endif

   assign rx_s         = sync_q[1];
   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_frame_err = ferr_q;
   assign rx_overrun   = ovr_q;
   assign rx_busy      = busy_q;

   // A frame completes on the stop-sample tick with a good stop bit (and good parity when enabled).
   always_comb begin
      frame_ok = baud_tick && (state_q == STOP) && (tcnt_q == TMAX) && rx_s;
`ifdef UART_RX_PARITY_EN
      frame_ok = frame_ok && !par_bad_q;
`endif
   end

   // Reset parks the FSM in BREAK so a line held low across reset cannot start a frame.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q    <= 2'b11;
         state_q   <= BREAK;
         tcnt_q    <= '0;
         bcnt_q    <= '0;
         shift_q   <= '0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         sync_q <= {sync_q[0], rx};
         ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q <= 1'b0;
`endif
         if (baud_tick) begin
            tcnt_q <= tcnt_q + 1'b1;
            case (state_q)
               IDLE: begin
                  if (!rx_s) begin
                     state_q <= START;
                     tcnt_q  <= TONE;
                     busy_q  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     par_bad_q <= 1'b0;
`endif
                  end
               end
               START: begin
                  if (tcnt_q == TMID) begin
                     if (!rx_s) begin
                        state_q <= DATA;
                        tcnt_q  <= '0;
                        bcnt_q  <= '0;
                     end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  end
               end
               DATA: begin
                  if (tcnt_q == TMAX) begin
                     shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                     if (bcnt_q == BLAST) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= PARITY;
`else
                        state_q <= STOP;
`endif
                     end else begin
                        bcnt_q <= bcnt_q + 1'b1;
                     end
                  end
               end
`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  if (tcnt_q == TMAX) begin
                     par_bad_q <= ((^shift_q) ^ rx_s) != PAR_ODD;
                     perr_q    <= ((^shift_q) ^ rx_s) != PAR_ODD;
                     state_q   <= STOP;
                  end
               end
`endif
               STOP: begin
                  if (tcnt_q == TMAX) begin
                     if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end else begin
                        ferr_q  <= 1'b1;
                        state_q <= BREAK;
                     end
                  end
               end
               BREAK: begin
                  if (rx_s) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end
               default: state_q <= BREAK;
            endcase
         end
      end
   end

   // Holding register handshake runs every cycle, independent of baud_tick.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else if (frame_ok) begin
         if (!valid_q || rx_ack) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
            ovr_q   <= 1'b0;
         end else begin
            ovr_q   <= 1'b1;
         end
      end else if (rx_ack && valid_q) begin
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: baud_tick every 4 clocks (64 clocks per bit), frames aligned to the tick phase.
module tb_uart_rx;

`ifdef UART_RX_PARITY_EN
   localparam int NB = 9;
`else
   localparam int NB = 8;
`endif
   localparam int FLEN   = (NB + 2) * 64;
   // Start detected 2 cycles after the falling edge; stop sampled 23+16*NB ticks after detection.
   localparam int STOP_K = 2 + (23 + 16 * NB) * 4;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic       baud_tick;
   logic       rx;
   logic       rx_ack;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_busy;
`ifdef UART_RX_PARITY_EN
   logic       rx_parity_err;
`endif

   logic [1:0] tick_cnt = 2'd0;
   int         n_vec = 0;
   int         n_err = 0;
   int         ferr_cnt = 0;
   int         perr_cnt = 0;
   logic       v_pre, v_post, b_pre, b_post;

   uart_rx dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .baud_tick    (baud_tick),
      .rx           (rx),
      .rx_ack       (rx_ack),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun),
      .rx_busy      (rx_busy)
`ifdef UART_RX_PARITY_EN
     ,.rx_parity_err(rx_parity_err)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) tick_cnt <= tick_cnt + 2'd1;
   assign baud_tick = (tick_cnt == 2'd3);

   always @(posedge sys_clk) begin
      if (rx_frame_err) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
      if (rx_parity_err) perr_cnt++;
`endif
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic ack_pulse;
      rx_ack = 1'b1;
      @(negedge sys_clk);
      rx_ack = 1'b0;
   endtask

   // Sends start, data LSB first, optional parity, stop; ack_at >= 0 raises rx_ack for that one cycle.
   task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip,
                             input int ack_at);
      logic fr [0:10];
      fr[0] = 1'b0;
      for (int i = 0; i < 8; i++) fr[1+i] = b[i];
      fr[9]    = (^b) ^ par_flip;
      fr[NB+1] = stop_b;
      while (tick_cnt != 2'd1) @(negedge sys_clk);
      for (int k = 0; k < FLEN; k++) begin
         if (k == STOP_K) begin
            v_pre = rx_valid;
            b_pre = rx_busy;
         end
         if (k == STOP_K + 1) begin
            v_post = rx_valid;
            b_post = rx_busy;
         end
         rx     = fr[k/64];
         rx_ack = (k == ack_at);
         @(negedge sys_clk);
      end
      rx_ack = 1'b0;
      if (stop_b) rx = 1'b1;
   endtask

   initial begin
      sys_rst_n = 1'b0;
      rx        = 1'b1;
      rx_ack    = 1'b0;
      idle(5);
      chk("reset_data",    rx_data,      0);
      chk("reset_valid",   rx_valid,     0);
      chk("reset_ferr",    rx_frame_err, 0);
      chk("reset_overrun", rx_overrun,   0);
      chk("reset_busy",    rx_busy,      0);
      sys_rst_n = 1'b1;
      idle(100);
      chk("idle_busy",  rx_busy,  0);
      chk("idle_valid", rx_valid, 0);

      // Basic 0xA5 frame: valid rises and busy falls one cycle after the stop-sample tick.
      send_frame(8'hA5, 1'b1, 1'b0, -1);
      chk("a5_valid_before", v_pre,  0);
      chk("a5_valid_after",  v_post, 1);
      chk("a5_busy_before",  b_pre,  1);
      chk("a5_busy_after",   b_post, 0);
      chk("a5_data",         rx_data, 8'hA5);
      chk("a5_ferr",         ferr_cnt, 0);
      ack_pulse();
      chk("a5_ack_valid", rx_valid, 0);

      // Three-tick low glitch on an idle line.
      idle(20);
      rx = 1'b0;
      idle(12);
      rx = 1'b1;
      idle(200);
      chk("glitch_valid",   rx_valid,   0);
      chk("glitch_ferr",    ferr_cnt,   0);
      chk("glitch_overrun", rx_overrun, 0);
      chk("glitch_busy",    rx_busy,    0);

      // Bad stop bit, long break, then a clean frame.
      send_frame(8'h3C, 1'b0, 1'b0, -1);
      chk("ferr_no_valid_edge", v_post, 0);
      idle(40 * 64);
      rx = 1'b1;
      idle(128);
      chk("ferr_count", ferr_cnt, 1);
      chk("ferr_valid", rx_valid, 0);
      chk("ferr_busy",  rx_busy,  0);
      send_frame(8'h5A, 1'b1, 1'b0, -1);
      chk("after_break_valid", rx_valid, 1);
      chk("after_break_data",  rx_data,  8'h5A);
      chk("after_break_ferr",  ferr_cnt, 1);
      ack_pulse();

      // Overrun: second frame arrives while the first is unacknowledged.
      send_frame(8'h11, 1'b1, 1'b0, -1);
      chk("ovr_first_data", rx_data,    8'h11);
      chk("ovr_first_flag", rx_overrun, 0);
      send_frame(8'h22, 1'b1, 1'b0, -1);
      chk("ovr_data_kept", rx_data,    8'h11);
      chk("ovr_valid",     rx_valid,   1);
      chk("ovr_flag",      rx_overrun, 1);
      ack_pulse();
      chk("ovr_ack_valid", rx_valid,   0);
      chk("ovr_ack_flag",  rx_overrun, 0);

      // Ack landing in the exact completion cycle of the next frame.
      send_frame(8'h33, 1'b1, 1'b0, -1);
      chk("ack_first_data", rx_data, 8'h33);
      send_frame(8'h44, 1'b1, 1'b0, STOP_K);
      chk("ackc_valid_before", v_pre,  1);
      chk("ackc_valid_after",  v_post, 1);
      chk("ackc_data",    rx_data,    8'h44);
      chk("ackc_valid",   rx_valid,   1);
      chk("ackc_overrun", rx_overrun, 0);
      ack_pulse();
      chk("ackc_cleared", rx_valid, 0);

      // Reset mid-data of 0x77, released while the line is low.
      while (tick_cnt != 2'd1) @(negedge sys_clk);
      rx = 1'b0;
      idle(64);
      rx = 1'b1;
      idle(3 * 64);
      rx = 1'b0;
      sys_rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", rx_busy, 0);
      idle(6);
      while (tick_cnt != 2'd0) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      idle(200);
      chk("rst_low_busy", rx_busy, 0);
      rx = 1'b1;
      idle(11 * 64);
      chk("rst_mid_valid", rx_valid, 0);
      chk("rst_mid_data",  rx_data,  0);
      send_frame(8'h81, 1'b1, 1'b0, -1);
      chk("post_rst_valid", rx_valid, 1);
      chk("post_rst_data",  rx_data,  8'h81);
      ack_pulse();

`ifdef UART_RX_PARITY_EN
      // Wrong even-parity bit on 0x07 (correct bit would be 1).
      send_frame(8'h07, 1'b1, 1'b1, -1);
      chk("par_err_count", perr_cnt, 1);
      chk("par_valid",     rx_valid, 0);
      chk("par_ferr",      ferr_cnt, 1);
      send_frame(8'h07, 1'b1, 1'b0, -1);
      chk("par_good_data",  rx_data,  8'h07);
      chk("par_good_count", perr_cnt, 1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
